// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encodings and latency helper for the ALU issue arbiter
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL = 5'd2;
    localparam logic [OP_W-1:0] OP_DIV = 5'd3;
    localparam logic [OP_W-1:0] OP_MOD = 5'd4;
    localparam logic [OP_W-1:0] OP_AND = 5'd5;
    localparam logic [OP_W-1:0] OP_OR  = 5'd6;
    localparam logic [OP_W-1:0] OP_XOR = 5'd7;
    localparam logic [OP_W-1:0] OP_SLL = 5'd8;
    localparam logic [OP_W-1:0] OP_SRL = 5'd9;
    localparam logic [OP_W-1:0] OP_SLT = 5'd10;
    localparam logic [OP_W-1:0] OP_SRA = 5'd11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_op_t;

    function automatic int op_latency(input logic [OP_W-1:0] op, input int mul_lat, input int div_lat);
        case (op)
            OP_MUL:         return mul_lat;
            OP_DIV, OP_MOD: return div_lat;
            default:        return 1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first asserted request at or after ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - shares one combinational ALU among requesters; ALU_ISSUE_ERR_EN adds rsp_err
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  MUL_LAT = 2,
    parameter int  DIV_LAT = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_type,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_type,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result
`ifdef ALU_ISSUE_ERR_EN
    ,
    output logic                      rsp_err
`endif
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    alu_op_t            op;
    logic [ID_W-1:0]    op_id;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any;
    logic [OP_W-1:0]    grant_type;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Reset gates the grant so req_ready is quiet while rst_n is low.
    assign req_ready  = (rst_n && state == IDLE) ? grant : '0;
    assign grant_type = req_type[int'(grant_idx)*OP_W +: OP_W];

    assign alu_a    = op.a;
    assign alu_b    = op.b;
    assign alu_type = op.op;
    assign rsp_id   = op_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            op         <= '0;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
`ifdef ALU_ISSUE_ERR_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op.a   <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        op.b   <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        op.op  <= grant_type;
                        op_id  <= grant_idx;
                        rr_ptr <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                        cnt    <= CNT_W'(op_latency(grant_type, MUL_LAT, DIV_LAT) - 1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands stay on alu_* for the whole count, giving the ALU its multicycle window.
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_valid  <= 1'b1;
`ifdef ALU_ISSUE_ERR_EN
                        rsp_err    <= ((op.op == OP_DIV || op.op == OP_MOD) && op.b == '0) || (op.op > OP_SRA);
`endif
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter with a behavioural ALU
module tb_alu_issue_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_type;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_type;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
`ifdef ALU_ISSUE_ERR_EN
    logic        rsp_err;
`endif

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] res;
        logic        err;
        int          acc;
        int          rise;
    } exp_t;

    exp_t sbq[$];
    int   id_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rsp_seen = 0;
    logic prev_valid = 1'b0;

    alu_issue_arbiter #(.NUM_REQ(2), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_type   (req_type),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_type   (alu_type),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_ISSUE_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_result = 32'd0;
        case (alu_type)
            5'd0:  alu_result = alu_a + alu_b;
            5'd1:  alu_result = alu_a - alu_b;
            5'd2:  alu_result = alu_a * alu_b;
            5'd3:  alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
            5'd4:  alu_result = (alu_b == 0) ? 32'd0 : alu_a % alu_b;
            5'd5:  alu_result = alu_a & alu_b;
            5'd6:  alu_result = alu_a | alu_b;
            5'd7:  alu_result = alu_a ^ alu_b;
            5'd8:  alu_result = alu_a << alu_b[4:0];
            5'd9:  alu_result = alu_a >> alu_b[4:0];
            5'd10: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            5'd11: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                rsp_seen <= rsp_seen + 1;
                if (sbq.size() == 0) begin
                    check("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!prev_valid) check("latency", cyc, sbq[0].rise);
                    check("rsp_id", 32'(rsp_id), sbq[0].id);
                    check("rsp_result", rsp_result, sbq[0].res);
                    check("resp_alu_a", alu_a, sbq[0].a);
                    check("resp_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_ISSUE_ERR_EN
                    check("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
`endif
                    if (rsp_ready) begin
                        id_log.push_back(sbq[0].id);
                        void'(sbq.pop_front());
                    end
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].acc) begin
                check("exec_alu_a", alu_a, sbq[0].a);
                check("exec_alu_b", alu_b, sbq[0].b);
                check("exec_alu_type", 32'(alu_type), 32'(sbq[0].op));
            end
        end
        prev_valid <= rst_n && rsp_valid;
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic [31:0] res, input logic err, input int lat, input bit push, input bit hold);
        int t = 0;
        req_a[id*32 +: 32]  = a;
        req_b[id*32 +: 32]  = b;
        req_type[id*5 +: 5] = op;
        req_valid[id]       = 1'b1;
        @(negedge clk);
        while (!req_ready[id] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[id]) begin
            check("grant_timeout", 32'(req_ready[id]), 32'd1);
            req_valid[id] = 1'b0;
            return;
        end
        if (push) sbq.push_back('{id: id, a: a, b: b, op: op, res: res, err: err, acc: cyc + 1, rise: cyc + 1 + lat});
        @(posedge clk);
        #1;
        if (!hold) req_valid[id] = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sbq.size() != 0 || rsp_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stream(input int id, input logic [31:0] base);
        for (int k = 0; k < 3; k++) issue(id, base, 32'd1, 5'd0, base + 32'd1, 1'b0, 1, 1'b1, k < 2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_result"}, rsp_result, 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_type"}, 32'(alu_type), 32'd0);
`ifdef ALU_ISSUE_ERR_EN
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
`endif
    endtask

    initial begin
        int t;
        int seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_type  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        issue(0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1, 1'b1, 1'b0);
        wait_done();

        issue(1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 4, 1'b1, 1'b0);
        wait_done();
        issue(1, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0, 4, 1'b1, 1'b0);
        wait_done();

        rsp_ready = 1'b0;
        issue(0, 32'd6, 32'd7, 5'd2, 32'd42, 1'b0, 2, 1'b1, 1'b0);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done();

        issue(0, 32'd9, 32'd0, 5'd4, 32'd0, 1'b1, 4, 1'b1, 1'b0);
        wait_done();
        issue(1, 32'd3, 32'd4, 5'd15, 32'd0, 1'b1, 1, 1'b1, 1'b0);
        wait_done();
        issue(0, 32'd9, 32'd4, 5'd1, 32'd5, 1'b0, 1, 1'b1, 1'b0);
        wait_done();

        issue(0, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        seen  = rsp_seen;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_exec_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_rsp_after_reset", rsp_seen - seen, 32'd0);

        id_log.delete();
        fork
            drive_stream(0, 32'd0);
            drive_stream(1, 32'd10);
        join
        wait_done();
        check("rr_count", id_log.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < id_log.size()) check($sformatf("rr_order_%0d", k), id_log[k], k % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
